// File: rtl/pattern_detector_if.sv
// pattern_detector_if: character stream in, sticky match flag out with consumer acknowledge
interface pattern_detector_if;
   logic [7:0] data;
   logic       ack;
   logic       found_pattern;
   modport master (output data, output ack, input found_pattern);
   modport slave (input data, input ack, output found_pattern);
endinterface

// File: rtl/pattern_detector.sv
// pattern_detector: flags each occurrence of "boabz" in a byte stream until acknowledged
module pattern_detector (
   input logic               clk,
   input logic               reset_sync,
   pattern_detector_if.slave bus
);
   typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;
   localparam logic [7:0] C_B = 8'h62;
   localparam logic [7:0] C_O = 8'h6F;
   localparam logic [7:0] C_A = 8'h61;
   localparam logic [7:0] C_Z = 8'h7A;
   state_t r_state, w_next;
   logic   r_found;
   logic   w_match;
   logic   w_is_b, w_is_o, w_is_a;
   assign w_is_b  = bus.data == C_B;
   assign w_is_o  = bus.data == C_O;
   assign w_is_a  = bus.data == C_A;
   assign w_match = (r_state == S4) && (bus.data == C_Z);
   // next prefix length, falling back to the longest proper suffix that is still a prefix
   always_comb begin
      w_next = S0;
      case (r_state)
         S0:      w_next = w_is_b ? S1 : S0;
         S1:      w_next = w_is_o ? S2 : w_is_b ? S1 : S0;
         S2:      w_next = w_is_a ? S3 : w_is_b ? S1 : S0;
         S3:      w_next = w_is_b ? S4 : S0;
         S4:      w_next = w_is_o ? S2 : w_is_b ? S1 : S0;
         default: w_next = S0;
      endcase
   end
   // match state and sticky flag; a new match outranks a same-edge ack
   always_ff @(posedge clk or negedge reset_sync) begin
      if (!reset_sync) begin
         r_state <= S0;
         r_found <= 1'b0;
      end else begin
         r_state <= w_next;
         r_found <= w_match ? 1'b1 : bus.ack ? 1'b0 : r_found;
      end
   end
   assign bus.found_pattern = r_found;
endmodule

// File: tb/tb_pattern_detector.sv
// tb_pattern_detector: directed vectors for the "boabz" detector
module tb_pattern_detector;
   logic clk = 1'b0;
   logic reset_sync = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   pattern_detector_if u_if ();
   pattern_detector dut (.clk(clk), .reset_sync(reset_sync), .bus(u_if));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic [7:0] d, input logic a);
      @(negedge clk);
      u_if.data = d;
      u_if.ack  = a;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset_sync = 1'b0;
      u_if.ack   = 1'b0;
      @(negedge clk);
      reset_sync = 1'b1;
   endtask
   // feed s byte by byte; am/em give per-byte ack and expected flag as '0'/'1'
   task automatic feed(input string tag, input string s, input string am, input string em);
      for (int i = 0; i < s.len(); i++) begin
         step(s[i], am[i] == "1");
         check($sformatf("%s[%0d]", tag, i), {7'b0, u_if.found_pattern}, {7'b0, em[i] == "1"});
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   initial begin
      u_if.data = 8'h62;
      u_if.ack  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_flag", {7'b0, u_if.found_pattern}, 8'h00);
      check("rst_state", {5'b0, dut.r_state}, 8'h00);
      @(negedge clk);
      reset_sync = 1'b1;
      feed("basic", "pbbboabzboabzboabz", "000000000000000000", "000000011111111111");
      #2;
      reset_sync = 1'b0;
      #1;
      check("async_rst", {7'b0, u_if.found_pattern}, 8'h00);
      @(negedge clk);
      reset_sync = 1'b1;
      feed("ack_clr", "pbbboabzboabzboabz", "000000001000000000", "000000010000111111");
      do_reset();
      feed("ovl1", "boaboabz", "00000000", "00000001");
      do_reset();
      feed("ovl2", "booabz", "000000", "000000");
      feed("ovl3", "boabbz", "000000", "000000");
      feed("ovl4", "boabboabz", "000000000", "000000001");
      do_reset();
      feed("ovl5", "bboabzoabz", "0000000000", "0000011111");
      do_reset();
      feed("simul", "boabzx", "000011", "000010");
      feed("ack_hold", "boabzboabzq", "11111111111", "00001000010");
      feed("case", "BOABZ", "00000", "00000");
      feed("noise", "boab", "0000", "0000");
      step(8'h00, 1'b0);
      check("noise_nul", {7'b0, u_if.found_pattern}, 8'h00);
      check("noise_state", {5'b0, dut.r_state}, 8'h00);
      feed("after_nul", "zoabz", "00000", "00000");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
